fp_issue_ctrl: RTL and testbench

FP_ISSUE_CTRL -- requirements
Module: fp_issue_ctrl

---
 rtl/fp_issue_ctrl.sv | 110 +++++++++++
 tb/tb_fp_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: issues decoded FP ops to a multicycle FPU, or forwards fmv operands directly,
// then presents a single writeback request; tracks RAW hazards, flush and FPU timeout.
module fp_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic        DSrc_D,
    input  logic        RegWriteF_D,
    input  logic        RegWrite_D,
    input  logic [4:0]  funct5_D,
    input  logic [2:0]  rm_D,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic [4:0]  rd_D,
    input  logic [31:0] srcA_D,
    input  logic [31:0] srcB_D,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_to_frf,
    output logic        wb_to_xrf,
    input  logic        flush,
    output logic        fp_busy,
    output logic        raw_hazard,
    output logic        fpu_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t      state_q;
    logic [4:0]  op_q, rd_q;
    logic [2:0]  rm_q;
    logic [31:0] a_q, b_q, data_q;
    logic        wf_q, wx_q, tmo_q;
    logic [7:0]  cnt_q;
    logic        is_fmv;

    assign is_fmv      = (op_q == 5'b11100) || (op_q == 5'b11110);
    assign fp_busy     = state_q != IDLE;
    assign raw_hazard  = fp_busy && wf_q && dec_valid && DSrc_D && (rs1_D == rd_q || rs2_D == rd_q);
    assign dec_ready   = (state_q == IDLE) && !raw_hazard;
    // flush in ISSUE must also squash the start pulse, so it stays combinational
    assign fpu_start   = (state_q == ISSUE) && !is_fmv && !flush;
    assign fpu_op      = op_q;
    assign fpu_rm      = rm_q;
    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
    assign wb_valid    = state_q == WB;
    assign wb_rd       = rd_q;
    assign wb_data     = data_q;
    assign wb_to_frf   = wf_q;
    assign wb_to_xrf   = wx_q;
    assign fpu_timeout = tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rm_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            wf_q    <= 1'b0;
            wx_q    <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (dec_valid && DSrc_D && dec_ready) begin
                    op_q    <= funct5_D;
                    rm_q    <= rm_D;
                    rd_q    <= rd_D;
                    a_q     <= srcA_D;
                    b_q     <= srcB_D;
                    wf_q    <= RegWriteF_D;
                    wx_q    <= RegWrite_D;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= flush ? IDLE : is_fmv ? WB : WAIT;
                    if (!flush && is_fmv) data_q <= a_q;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (flush) state_q <= IDLE;
                    else if (fpu_done) begin
                        data_q  <= fpu_result;
                        state_q <= WB;
                    end else if (cnt_q == 8'd254) begin
                        // 255th WAIT cycle without a result: give up, no writeback
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WB: if (wb_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl: scoreboard bench; stimulus pushes expected FPU issues and writebacks,
// an FPU responder and a writeback monitor pop and compare them independently.
module tb_fp_issue_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        dec_valid = 1'b0, DSrc_D = 1'b0, RegWriteF_D = 1'b0, RegWrite_D = 1'b0;
    logic [4:0]  funct5_D = '0, rs1_D = '0, rs2_D = '0, rd_D = '0;
    logic [2:0]  rm_D = '0;
    logic [31:0] srcA_D = '0, srcB_D = '0;
    logic        dec_ready, fpu_start;
    logic [4:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_result = '0;
    logic        wb_valid, wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_to_frf, wb_to_xrf;
    logic        flush = 1'b0, fp_busy, raw_hazard, fpu_timeout;

    int n_chk = 0, n_fail = 0;

    typedef struct packed {logic [4:0] rd; logic [31:0] data; logic frf; logic xrf;} wb_t;
    typedef struct packed {logic [4:0] op; logic [2:0] rm; logic [31:0] a; logic [31:0] b;} iss_t;
    wb_t  wb_q[$];
    iss_t iss_q[$];

    int          fpu_delay = 1;
    logic        fpu_spur = 1'b0, fpu_nodone = 1'b0;
    logic [31:0] fpu_res = '0;
    logic        bp_force = 1'b0, bp_val = 1'b1, tmo_exp = 1'b0;

    fp_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .DSrc_D(DSrc_D), .RegWriteF_D(RegWriteF_D), .RegWrite_D(RegWrite_D),
        .funct5_D(funct5_D), .rm_D(rm_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
        .srcA_D(srcA_D), .srcB_D(srcB_D),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_done(fpu_done), .fpu_result(fpu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_to_frf(wb_to_frf), .wb_to_xrf(wb_to_xrf),
        .flush(flush), .fp_busy(fp_busy), .raw_hazard(raw_hazard), .fpu_timeout(fpu_timeout)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // writeback monitor: every WB cycle must match the head of the queue; pop on handshake
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (wb_q.size() == 0) check("wb_unexpected", wb_valid, 1'b0);
            else begin
                check("wb_rd", wb_rd, wb_q[0].rd);
                check("wb_data", wb_data, wb_q[0].data);
                check("wb_to_frf", wb_to_frf, wb_q[0].frf);
                check("wb_to_xrf", wb_to_xrf, wb_q[0].xrf);
                if (wb_ready) void'(wb_q.pop_front());
            end
        end
    end

    // FPU responder: checks the issued op, optionally drives a done in the start cycle
    initial begin
        iss_t e;
        forever begin
            @(negedge clk);
            if (rst_n && fpu_start) begin
                if (iss_q.size() == 0) check("start_unexpected", fpu_start, 1'b0);
                else begin
                    e = iss_q.pop_front();
                    check("fpu_op", fpu_op, e.op);
                    check("fpu_rm", fpu_rm, e.rm);
                    check("fpu_a", fpu_a, e.a);
                    check("fpu_b", fpu_b, e.b);
                end
                if (fpu_spur) begin
                    fpu_done = 1'b1;
                    fpu_result = 32'hBAD0BAD0;
                end
                repeat (fpu_delay) begin
                    @(posedge clk);
                    #1 fpu_done = 1'b0;
                end
                if (!fpu_nodone) begin
                    fpu_done = 1'b1;
                    fpu_result = fpu_res;
                    @(posedge clk);
                    #1 fpu_done = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1 wb_ready = bp_force ? bp_val : ($urandom_range(0, 2) != 0);
    end

    // fl: -1 none, 0 flush in ISSUE, k>0 flush in k-th WAIT cycle (k <= d)
    task automatic run_txn(input logic dsrc, input logic [4:0] f5, input logic [2:0] rm,
                           input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic wf, input logic wx, input int d,
                           input logic spur, input logic nodone, input int fl,
                           input logic pdsrc, input logic [4:0] prs1, input logic [4:0] prs2);
        logic fmv;
        int n;
        fmv = (f5 == 5'b11100) || (f5 == 5'b11110);
        @(posedge clk);
        #1;
        dec_valid = 1'b1; DSrc_D = dsrc; funct5_D = f5; rm_D = rm; rd_D = rd;
        srcA_D = a; srcB_D = b; RegWriteF_D = wf; RegWrite_D = wx;
        rs1_D = 5'($urandom); rs2_D = 5'($urandom);
        @(negedge clk);
        check("dec_ready_idle", dec_ready, 1'b1);
        if (!dsrc) begin
            @(posedge clk);
            #1 dec_valid = 1'b0;
            @(negedge clk);
            check("non_fp_ignored", fp_busy, 1'b0);
            return;
        end
        fpu_delay = d; fpu_spur = spur; fpu_nodone = nodone; fpu_res = res;
        if (!fmv && fl != 0) iss_q.push_back('{f5, rm, a, b});
        if (fl < 0 && !nodone) wb_q.push_back('{rd, fmv ? a : res, wf, wx});
        @(posedge clk);
        #1;
        DSrc_D = pdsrc; rs1_D = prs1; rs2_D = prs2; flush = (fl == 0);
        @(negedge clk);
        check("busy_issue", fp_busy, 1'b1);
        check("ready_issue", dec_ready, 1'b0);
        check("raw_hazard", raw_hazard, pdsrc && wf && (prs1 == rd || prs2 == rd));
        check("start_issue", fpu_start, !fmv && fl != 0);
        @(posedge clk);
        #1 dec_valid = 1'b0;
        flush = 1'b0;
        if (fl == 0) begin
            @(negedge clk);
            check("flush_issue_idle", fp_busy, 1'b0);
            repeat (3) @(posedge clk);
            return;
        end
        if (fmv) begin
            @(negedge clk);
            check("fmv_latency", wb_valid, 1'b1);
        end else if (nodone) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!fpu_timeout && n < 400);
            check("timeout_cycles", n, 256);
            check("timeout_idle", fp_busy, 1'b0);
            check("timeout_wb", wb_valid, 1'b0);
            tmo_exp = 1'b1;
        end else begin
            for (int w = 1; w <= d; w++) begin
                flush = (w == fl);
                @(negedge clk);
                check("wait_no_wb", wb_valid, 1'b0);
                check("start_once", fpu_start, 1'b0);
                check("fpu_a_hold", fpu_a, a);
                check("fpu_op_hold", fpu_op, f5);
                @(posedge clk);
                #1 flush = 1'b0;
            end
            @(negedge clk);
            if (fl > 0) check("flush_wait_idle", fp_busy, 1'b0);
            else check("fpu_latency", wb_valid, 1'b1);
        end
        n = 0;
        while (fp_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("return_idle", fp_busy, 1'b0);
        check("timeout_sticky", fpu_timeout, tmo_exp);
    endtask

    task automatic rand_txns(input int cnt);
        logic [4:0] f5, rd;
        logic fmv;
        int d, r, fl;
        for (int i = 0; i < cnt; i++) begin
            f5 = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) != 0 ? 5'b11100 : 5'b11110) : 5'($urandom);
            fmv = (f5 == 5'b11100) || (f5 == 5'b11110);
            rd = 5'($urandom);
            d = int'($urandom_range(1, 6));
            r = int'($urandom_range(0, 5));
            fl = (r == 0) ? 0 : (r == 1 && !fmv) ? int'($urandom_range(1, d)) : -1;
            run_txn($urandom_range(0, 7) != 0, f5, 3'($urandom), rd, $urandom, $urandom, $urandom,
                    1'($urandom), 1'($urandom), d, $urandom_range(0, 3) == 0, 1'b0, fl,
                    1'($urandom), ($urandom_range(0, 1) != 0) ? rd : 5'($urandom), 5'($urandom));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_start", fpu_start, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_dec_ready", dec_ready, 1'b1);
        check("rst_busy", fp_busy, 1'b0);
        check("rst_timeout", fpu_timeout, 1'b0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_rd", wb_rd, 5'h0);
        check("rst_fpu_a", fpu_a, 32'h0);
        check("rst_fpu_op", fpu_op, 5'h0);

        run_txn(1, 5'b00000, 3'd0, 5'd3, 32'h3F800000, 32'h40000000, 32'h40400000, 1, 0, 4, 0, 0, -1, 1, 5'd0, 5'd0);
        run_txn(1, 5'b11100, 3'd0, 5'd7, 32'hDEADBEEF, 32'h0, 32'h0, 0, 1, 1, 0, 0, -1, 1, 5'd0, 5'd0);
        run_txn(1, 5'b00001, 3'd1, 5'd5, 32'h11111111, 32'h22222222, 32'h33333333, 1, 0, 5, 0, 0, -1, 1, 5'd1, 5'd5);
        run_txn(1, 5'b00010, 3'd2, 5'd4, 32'h44444444, 32'h55555555, 32'h66666666, 1, 0, 3, 0, 0, 2, 0, 5'd4, 5'd4);
        run_txn(1, 5'b00100, 3'd3, 5'd6, 32'h77777777, 32'h88888888, 32'h99999999, 1, 0, 2, 0, 0, 2, 1, 5'd6, 5'd0);
        run_txn(1, 5'b00101, 3'd4, 5'd8, 32'hAAAA0000, 32'h0000BBBB, 32'hCCCCDDDD, 0, 1, 1, 1, 0, -1, 1, 5'd8, 5'd8);
        run_txn(0, 5'b00000, 3'd0, 5'd9, 32'h1, 32'h2, 32'h3, 1, 0, 1, 0, 0, -1, 0, 5'd0, 5'd0);
        rand_txns(20);

        run_txn(1, 5'b00011, 3'd0, 5'd10, 32'h01020304, 32'h05060708, 32'h0, 1, 0, 1, 0, 1, -1, 0, 5'd0, 5'd0);
        rand_txns(20);

        bp_force = 1'b1;
        bp_val = 1'b0;
        @(posedge clk);
        #1;
        dec_valid = 1'b1; DSrc_D = 1'b1; funct5_D = 5'b11110; rd_D = 5'd9;
        srcA_D = 32'h12345678; RegWriteF_D = 1'b1; RegWrite_D = 1'b0;
        wb_q.push_back('{5'd9, 32'h12345678, 1'b1, 1'b0});
        @(posedge clk);
        #1 dec_valid = 1'b0;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_valid", wb_valid, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_wb_valid", wb_valid, 1'b0);
        check("rst_in_wb_busy", fp_busy, 1'b0);
        check("rst_in_wb_data", wb_data, 32'h0);
        check("rst_clears_timeout", fpu_timeout, 1'b0);
        wb_q.delete();
        tmo_exp = 1'b0;
        bp_force = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1, 5'b11110, 3'd0, 5'd11, 32'hCAFEF00D, 32'h0, 32'h0, 1, 1, 1, 0, 0, -1, 0, 5'd0, 5'd0);
        repeat (5) @(posedge clk);
        check("wb_queue_empty", wb_q.size(), 0);
        check("iss_queue_empty", iss_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
